// File: rtl/vga_pat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pat_pkg
// Purpose  : Mode/state encodings and colour constants for the VGA pattern scheduler.
// Revision : 1.0
// ============================================================================
package vga_pat_pkg;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_GRID  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_PEND = 2'd3;

  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_WHITE = 24'hffffff;
  localparam logic [23:0] RGB_BLUE  = 24'h0000ff;

  localparam logic [23:0] BAR_C0 = 24'hffffff;
  localparam logic [23:0] BAR_C1 = 24'hffff00;
  localparam logic [23:0] BAR_C2 = 24'h00ffff;
  localparam logic [23:0] BAR_C3 = 24'h00ff00;
  localparam logic [23:0] BAR_C4 = 24'hff00ff;
  localparam logic [23:0] BAR_C5 = 24'hff0000;
  localparam logic [23:0] BAR_C6 = 24'h0000ff;
  localparam logic [23:0] BAR_C7 = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_C0;
      3'd1:    c = BAR_C1;
      3'd2:    c = BAR_C2;
      3'd3:    c = BAR_C3;
      3'd4:    c = BAR_C4;
      3'd5:    c = BAR_C5;
      3'd6:    c = BAR_C6;
      default: c = BAR_C7;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pat_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pat_gen
// Purpose  : Combinational pixel colour for the selected pattern at (hcount, vcount).
// Revision : 1.0
// ============================================================================
module vga_pat_gen
  import vga_pat_pkg::*;
#(
  parameter int          BAR_W     = 80,
  parameter int          CELL_LOG2 = 5,
  parameter logic [23:0] SOLID_RGB = 24'hffffff
) (
  input  logic [1:0]         mode_i,
  input  logic [9:0]         hcount_i,
  input  logic [CELL_LOG2:0] vcount_i,
  input  logic               active_i,
  output logic [23:0]        rgb_o
);

  localparam logic [9:0] BAR_W10 = 10'(BAR_W);

  logic [9:0] bar_div;
  logic [2:0] bar_idx;

  always_comb begin
    bar_div = hcount_i / BAR_W10;
    // Anything right of the eighth bar keeps the last (black) bar colour.
    bar_idx = (bar_div > 10'd7) ? 3'd7 : bar_div[2:0];
    rgb_o   = RGB_BLACK;
    if (active_i) begin
      case (mode_i)
        MODE_BARS:  rgb_o = bar_colour(bar_idx);
        MODE_CHECK: rgb_o = (hcount_i[CELL_LOG2] ^ vcount_i[CELL_LOG2]) ? RGB_WHITE : RGB_BLACK;
        MODE_GRID:  rgb_o = ((hcount_i[CELL_LOG2-1:0] == '0) || (vcount_i[CELL_LOG2-1:0] == '0))
                            ? RGB_WHITE : RGB_BLUE;
        default:    rgb_o = SOLID_RGB;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_pat_sched.sv
`default_nettype none
// ============================================================================
// Module   : vga_pat_sched
// Purpose  : Frame-synchronous test-pattern scheduler feeding vga_ctrl data_in.
//            Define VGA_PAT_AUTO_EN to enable per-frame auto-cycling of patterns.
// Revision : 1.0
// ============================================================================
module vga_pat_sched
  import vga_pat_pkg::*;
#(
  parameter int          H_ACTIVE       = 640,
  parameter int          V_ACTIVE       = 480,
  parameter int          BAR_W          = 80,
  parameter int          CELL_LOG2      = 5,
  parameter int          FRAMES_PER_PAT = 60,
  parameter logic [23:0] SOLID_RGB      = 24'hffffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        vga_vs,
  input  logic        req_valid,
  input  logic [1:0]  req_mode,
  output logic        req_ready,
  output logic [23:0] data_out,
  output logic [1:0]  cur_mode,
  output logic        busy
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cur_mode_q, cur_mode_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic        vs_q;
  logic [23:0] data_out_q;
  logic [23:0] pix_rgb;
  logic        fb;
  logic        req_acc;
  logic        pix_active;
  logic        auto_step;

  assign fb      = ~vs_q & vga_vs;
  assign req_acc = req_valid & req_ready;

`ifdef VGA_PAT_AUTO_EN
  localparam int             CNT_W    = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PAT - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign auto_step = (frame_cnt_q == CNT_LAST);

  // Counter only runs while displaying; every way back into RUN starts from zero.
  always_comb begin
    frame_cnt_d = '0;
    if (state_q == ST_RUN) begin
      frame_cnt_d = frame_cnt_q;
      if (en && fb) frame_cnt_d = auto_step ? '0 : frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_cnt_q <= '0;
    else      frame_cnt_q <= frame_cnt_d;
  end
`else
  localparam int c_unused_fpp = FRAMES_PER_PAT;
  assign auto_step = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_ARM;
      ST_ARM:  if (!en) state_d = ST_IDLE; else if (fb) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_IDLE; else if (req_acc) state_d = ST_PEND;
      ST_PEND: if (!en) state_d = ST_IDLE; else if (fb) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b1;
    busy      = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_PEND: begin
        busy      = 1'b1;
        req_ready = 1'b0;
      end
      default: ;
    endcase
  end

  // While blanked a request lands immediately; while displaying it waits for fb.
  always_comb begin
    cur_mode_d  = cur_mode_q;
    pend_mode_d = pend_mode_q;
    if (req_acc) pend_mode_d = req_mode;
    case (state_q)
      ST_IDLE, ST_ARM: if (req_acc) cur_mode_d = req_mode;
      ST_RUN: begin
        if (!en && req_acc)           cur_mode_d = req_mode;
        else if (en && fb && auto_step) cur_mode_d = cur_mode_q + 2'd1;
      end
      ST_PEND: if (!en || fb) cur_mode_d = pend_mode_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_mode_q  <= MODE_BARS;
      pend_mode_q <= MODE_BARS;
      vs_q        <= 1'b0;
      data_out_q  <= RGB_BLACK;
    end else begin
      cur_mode_q  <= cur_mode_d;
      pend_mode_q <= pend_mode_d;
      vs_q        <= vga_vs;
      data_out_q  <= pix_rgb;
    end
  end

  assign pix_active = ((state_q == ST_RUN) || (state_q == ST_PEND)) &&
                      ({1'b0, hcount} < H_LIM) && ({1'b0, vcount} < V_LIM);

  vga_pat_gen #(
    .BAR_W     (BAR_W),
    .CELL_LOG2 (CELL_LOG2),
    .SOLID_RGB (SOLID_RGB)
  ) u_gen (
    .mode_i   (cur_mode_q),
    .hcount_i (hcount),
    .vcount_i (vcount[CELL_LOG2:0]),
    .active_i (pix_active),
    .rgb_o    (pix_rgb)
  );

  assign data_out = data_out_q;
  assign cur_mode = cur_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pat_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pat_sched
// Purpose  : Self-checking bench for vga_pat_sched against a frame/pixel reference model.
// Revision : 1.0
// ============================================================================
module tb_vga_pat_sched;

  localparam logic [23:0] SOLID = 24'h3c5a96;

  logic        clk = 1'b0;
  logic        rst, en, vga_vs, req_valid;
  logic [9:0]  hcount, vcount;
  logic [1:0]  req_mode;
  logic        req_ready, busy;
  logic [23:0] data_out;
  logic [1:0]  cur_mode;

  int vectors    = 0;
  int miscompares = 0;
  int exp_mode   = 0;

  logic [23:0] bars [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                           24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

  always #5 clk = ~clk;

  vga_pat_sched #(
    .H_ACTIVE       (640),
    .V_ACTIVE       (480),
    .BAR_W          (80),
    .CELL_LOG2      (5),
    .FRAMES_PER_PAT (2),
    .SOLID_RGB      (SOLID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hcount    (hcount),
    .vcount    (vcount),
    .vga_vs    (vga_vs),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .data_out  (data_out),
    .cur_mode  (cur_mode),
    .busy      (busy)
  );

  function automatic logic [23:0] ref_pix(int m, int h, int v, bit shown);
    int b;
    if (!shown || h >= 640 || v >= 480) return 24'h0;
    case (m)
      0: begin
        b = h / 80;
        if (b > 7) b = 7;
        return bars[b];
      end
      1: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hffffff : 24'h000000;
      2: return (((h % 32) == 0) || ((v % 32) == 0)) ? 24'hffffff : 24'h0000ff;
      default: return SOLID;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    vga_vs = 1'b1;
    tick();
    vga_vs = 1'b0;
    tick();
  endtask

  task automatic set_mode(input int m);
    req_mode  = 2'(m);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    frame_pulse();
    exp_mode = m;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; vga_vs = 1'b0; req_valid = 1'b0; req_mode = 2'd0;
    hcount = 10'd0; vcount = 10'd0;
    repeat (10) tick();
    vectors += 4;
    if (data_out !== 24'h0) begin miscompares++; $display("FAIL rst_data_out got %h want %h", data_out, 24'h0); end
    if (cur_mode !== 2'd0)  begin miscompares++; $display("FAIL rst_cur_mode got %0d want 0", cur_mode); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b1;
    repeat (4) tick();
    vectors += 2;
    if (data_out !== 24'h0) begin miscompares++; $display("FAIL pre_fb_black got %h want %h", data_out, 24'h0); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL pre_fb_busy got %b want 0", busy); end
    frame_pulse();
    exp_mode = 0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL post_fb_busy got %b want 1", busy); end
    hcount = 10'd0; vcount = 10'd0; tick();
    vectors++;
    if (data_out !== 24'hffffff) begin miscompares++; $display("FAIL px_0_0 got %h want ffffff", data_out); end
    hcount = 10'd80; tick();
    vectors++;
    if (data_out !== 24'hffff00) begin miscompares++; $display("FAIL px_80_0 got %h want ffff00", data_out); end
  endtask

  task automatic test_patterns();
    int base, m, h, v;
    logic [23:0] exp;
    base = int'($urandom_range(0, 3));
    for (int k = 0; k < 4; k++) begin
      m = (base + k) % 4;
      set_mode(m);
      vectors++;
      if (cur_mode !== 2'(m)) begin miscompares++; $display("FAIL pat_mode got %0d want %0d", cur_mode, m); end
      for (int i = 0; i < 12; i++) begin
        h = int'($urandom_range(0, 700));
        v = int'($urandom_range(0, 520));
        hcount = 10'(h); vcount = 10'(v);
        tick();
        exp = ref_pix(m, h, v, 1'b1);
        vectors++;
        if (data_out !== exp) begin
          miscompares++;
          $display("FAIL pat_px m=%0d (%0d,%0d) got %h want %h", m, h, v, data_out, exp);
        end
      end
    end
  endtask

  task automatic test_blanking();
    int hs [4] = '{640, 0, 639, 700};
    int vs [4] = '{0, 480, 479, 479};
    logic [23:0] exp;
    set_mode(3);
    for (int i = 0; i < 4; i++) begin
      hcount = 10'(hs[i]); vcount = 10'(vs[i]);
      tick();
      exp = ref_pix(3, hs[i], vs[i], 1'b1);
      vectors++;
      if (data_out !== exp) begin
        miscompares++;
        $display("FAIL blank_px (%0d,%0d) got %h want %h", hs[i], vs[i], data_out, exp);
      end
    end
  endtask

  task automatic test_req_hold();
    set_mode(0);
    hcount = 10'd100; vcount = 10'd200;
    req_mode = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    vectors += 3;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready got %b want 0", req_ready); end
    if (cur_mode !== 2'd0)  begin miscompares++; $display("FAIL hold_mode got %0d want 0", cur_mode); end
    if (busy !== 1'b1)      begin miscompares++; $display("FAIL hold_busy got %b want 1", busy); end
    req_mode = 2'd3; req_valid = 1'b1;
    repeat (5) tick();
    req_valid = 1'b0;
    vectors += 2;
    if (cur_mode !== 2'd0) begin miscompares++; $display("FAIL hold_midframe got %0d want 0", cur_mode); end
    if (data_out !== ref_pix(0, 100, 200, 1'b1)) begin
      miscompares++; $display("FAIL hold_px got %h want %h", data_out, ref_pix(0, 100, 200, 1'b1));
    end
    vga_vs = 1'b1;
    tick();
    vectors += 2;
    if (cur_mode !== 2'd2)  begin miscompares++; $display("FAIL hold_apply got %0d want 2", cur_mode); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL hold_ready_back got %b want 1", req_ready); end
    vga_vs = 1'b0;
    tick();
    exp_mode = 2;
    hcount = 10'd32; vcount = 10'd5; tick();
    vectors++;
    if (data_out !== 24'hffffff) begin miscompares++; $display("FAIL grid_32_5 got %h want ffffff", data_out); end
    hcount = 10'd33; tick();
    vectors++;
    if (data_out !== 24'h0000ff) begin miscompares++; $display("FAIL grid_33_5 got %h want 0000ff", data_out); end
  endtask

  task automatic test_auto();
`ifdef VGA_PAT_AUTO_EN
    int want;
    set_mode(0);
    for (int k = 1; k <= 8; k++) begin
      frame_pulse();
      want = (k / 2) % 4;
      vectors++;
      if (cur_mode !== 2'(want)) begin
        miscompares++; $display("FAIL auto_seq fb=%0d got %0d want %0d", k, cur_mode, want);
      end
    end
    frame_pulse();
    req_mode = 2'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    frame_pulse();
    exp_mode = 3;
    vectors++;
    if (cur_mode !== 2'd3) begin miscompares++; $display("FAIL auto_prio got %0d want 3", cur_mode); end
`else
    set_mode(1);
    for (int k = 1; k <= 6; k++) begin
      frame_pulse();
      vectors++;
      if (cur_mode !== 2'd1) begin
        miscompares++; $display("FAIL noauto_hold fb=%0d got %0d want 1", k, cur_mode);
      end
    end
`endif
  endtask

  task automatic test_en_drop();
    set_mode(2);
    req_mode = 2'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL drop_pend_ready got %b want 0", req_ready); end
    en = 1'b0;
    hcount = 10'd32; vcount = 10'd0;
    tick();
    vectors += 3;
    if (cur_mode !== 2'd1)  begin miscompares++; $display("FAIL drop_mode got %0d want 1", cur_mode); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL drop_ready got %b want 1", req_ready); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL drop_busy got %b want 0", busy); end
    exp_mode = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      hcount = 10'($urandom_range(0, 639)); vcount = 10'($urandom_range(0, 479));
      tick();
      vectors++;
      if (data_out !== 24'h0) begin miscompares++; $display("FAIL drop_black got %h want 000000", data_out); end
    end
    en = 1'b1;
    hcount = 10'd32; vcount = 10'd0;
    repeat (3) tick();
    vectors++;
    if (data_out !== 24'h0) begin miscompares++; $display("FAIL rearm_black got %h want 000000", data_out); end
    frame_pulse();
    tick();
    vectors++;
    if (data_out !== ref_pix(1, 32, 0, 1'b1)) begin
      miscompares++; $display("FAIL resume_px got %h want %h", data_out, ref_pix(1, 32, 0, 1'b1));
    end
  endtask

  task automatic test_async_reset();
    set_mode(3);
    hcount = 10'd10; vcount = 10'd10;
    tick();
    vectors++;
    if (data_out !== SOLID) begin miscompares++; $display("FAIL pre_arst_px got %h want %h", data_out, SOLID); end
    #2;
    rst = 1'b0;
    #1;
    vectors += 4;
    if (data_out !== 24'h0) begin miscompares++; $display("FAIL arst_data got %h want 000000", data_out); end
    if (cur_mode !== 2'd0)  begin miscompares++; $display("FAIL arst_mode got %0d want 0", cur_mode); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready got %b want 1", req_ready); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL arst_busy got %b want 0", busy); end
    tick();
    rst = 1'b1;
    exp_mode = 0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_patterns();
    test_blanking();
    test_req_hold();
    test_auto();
    test_en_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
